// File: rtl/smc_wr_strobe_lite.sv
// Write-strobe timing generator for the lite SMC write path: setup / strobe / hold sequencing
// with registered active-low strobe outputs and a one-cycle ack in the last access cycle.
module smc_wr_strobe_lite #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             sys_clk,
    input  logic             n_sys_reset,
    input  logic             wr_req,
    input  logic [3:0]       wr_be,
    input  logic [CNT_W-1:0] cfg_setup,
    input  logic [CNT_W-1:0] cfg_strobe,
    input  logic [CNT_W-1:0] cfg_hold,
    output logic             wr_busy,
    output logic             wr_ack,
    output logic             r_full,
    output logic [3:0]       n_r_we,
    output logic             n_r_wr
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] strobe_q, strobe_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [3:0]       be_q, be_d;

    logic             busy_d, ack_d, full_d, wr_d;
    logic [3:0]       we_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        strobe_d = strobe_q;
        hold_d   = hold_q;
        be_d     = be_q;
        case (state_q)
            StIdle: begin
                if (wr_req) begin
                    be_d     = wr_be;
                    strobe_d = cfg_strobe;
                    hold_d   = cfg_hold;
                    if (cfg_setup != '0) begin
                        state_d = StSetup;
                        cnt_d   = cfg_setup - CntOne;
                    end else begin
                        state_d = StStrobe;
                        cnt_d   = cfg_strobe;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StStrobe;
                    cnt_d   = strobe_q;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    if (hold_q != '0) begin
                        state_d = StHold;
                        cnt_d   = hold_q - CntOne;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the next state so the registered pins line up with the state they describe.
    always_comb begin
        busy_d = (state_d != StIdle);
        full_d = (state_d == StStrobe);
        wr_d   = ~full_d;
        we_d   = full_d ? ~be_d : 4'hF;
        ack_d  = (cnt_d == '0) &&
                 ((state_d == StHold) || ((state_d == StStrobe) && (hold_d == '0)));
    end

    always_ff @(posedge sys_clk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            strobe_q <= '0;
            hold_q   <= '0;
            be_q     <= 4'h0;
            wr_busy  <= 1'b0;
            wr_ack   <= 1'b0;
            r_full   <= 1'b0;
            n_r_we   <= 4'hF;
            n_r_wr   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            hold_q   <= hold_d;
            be_q     <= be_d;
            wr_busy  <= busy_d;
            wr_ack   <= ack_d;
            r_full   <= full_d;
            n_r_we   <= we_d;
            n_r_wr   <= wr_d;
        end
    end

endmodule

// File: tb/tb_smc_wr_strobe_lite.sv
// Bench for smc_wr_strobe_lite: per-cycle timeline model plus hand-computed literal checks.
module tb_smc_wr_strobe_lite;

    logic       sys_clk = 1'b0;
    logic       n_sys_reset;
    logic       wr_req;
    logic [3:0] wr_be;
    logic [2:0] cfg_setup, cfg_strobe, cfg_hold;
    logic       wr_busy, wr_ack, r_full, n_r_wr;
    logic [3:0] n_r_we;
    logic [7:0] outs;

    int n_cmp = 0;
    int n_err = 0;

    // Output vector layout: {busy, ack, full, n_we[3:0], n_wr}
    localparam logic [7:0] IdleV = 8'b0_0_0_1111_1;

    logic [7:0] mq[$];

    smc_wr_strobe_lite #(.CNT_W(3)) dut (
        .sys_clk     (sys_clk),
        .n_sys_reset (n_sys_reset),
        .wr_req      (wr_req),
        .wr_be       (wr_be),
        .cfg_setup   (cfg_setup),
        .cfg_strobe  (cfg_strobe),
        .cfg_hold    (cfg_hold),
        .wr_busy     (wr_busy),
        .wr_ack      (wr_ack),
        .r_full      (r_full),
        .n_r_we      (n_r_we),
        .n_r_wr      (n_r_wr)
    );

    assign outs = {wr_busy, wr_ack, r_full, n_r_we, n_r_wr};

    always #5 sys_clk = ~sys_clk;

    task automatic build(input logic [2:0] s, input logic [2:0] st, input logic [2:0] h,
                         input logic [3:0] be);
        for (int i = 0; i < int'(s); i++) mq.push_back(8'b1_0_0_1111_1);
        for (int i = 0; i <= int'(st); i++) mq.push_back({3'b101, ~be, 1'b0});
        for (int i = 0; i < int'(h); i++) mq.push_back(8'b1_0_0_1111_1);
        mq[mq.size()-1][6] = 1'b1;
    endtask

    // Queue holds one expected vector per remaining access cycle; empty means idle.
    always @(posedge sys_clk or negedge n_sys_reset) begin
        if (!n_sys_reset) mq.delete();
        else if (mq.size() != 0) void'(mq.pop_front());
        else if (wr_req) build(cfg_setup, cfg_strobe, cfg_hold, wr_be);
    end

    always @(negedge sys_clk) begin
        logic [7:0] exp_v;
        if (n_sys_reset) begin
            exp_v = (mq.size() != 0) ? mq[0] : IdleV;
            n_cmp++;
            if (outs !== exp_v) begin
                n_err++;
                $display("FAIL model_cycle t=%0t got=%b expected=%b", $time, outs, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, got, exp_v);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge inside cycle 0 of the access.
    task automatic start(input logic [2:0] s, input logic [2:0] st, input logic [2:0] h,
                         input logic [3:0] be);
        cfg_setup  = s;
        cfg_strobe = st;
        cfg_hold   = h;
        wr_be      = be;
        wr_req     = 1'b1;
        @(negedge sys_clk);
        wr_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge sys_clk);
            if (mq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle timeout t=%0t got=busy expected=idle", $time);
        end
    endtask

    initial begin
        int n_strb, n_ack, n_busy;
        n_sys_reset = 1'b0;
        wr_req      = 1'b0;
        wr_be       = 4'h0;
        cfg_setup   = '0;
        cfg_strobe  = '0;
        cfg_hold    = '0;
        repeat (2) @(negedge sys_clk);
        chk("reset_state", outs, IdleV);
        n_sys_reset = 1'b1;
        @(negedge sys_clk);

        // T1 + T3: late cfg changes and a busy-time request must have no effect
        start(3'd1, 3'd2, 3'd1, 4'b0011);
        chk("t1_c0", outs, 8'b1_0_0_1111_1);
        cfg_setup = 3'd7; cfg_strobe = 3'd7; cfg_hold = 3'd7;
        @(negedge sys_clk); chk("t1_c1", outs, 8'b1_0_1_1100_0);
        @(negedge sys_clk); chk("t1_c2", outs, 8'b1_0_1_1100_0);
        wr_req = 1'b1; wr_be = 4'hF;
        @(negedge sys_clk); chk("t1_c3", outs, 8'b1_0_1_1100_0);
        wr_req = 1'b0;
        @(negedge sys_clk); chk("t1_c4_ack", outs, 8'b1_1_0_1111_1);
        @(negedge sys_clk); chk("t1_c5_idle", outs, IdleV);

        // T2: single-cycle access, back-to-back request after one idle cycle
        start(3'd0, 3'd0, 3'd0, 4'hF);
        chk("t2_c0", outs, 8'b1_1_1_0000_0);
        cfg_setup = 3'd1; cfg_strobe = 3'd0; cfg_hold = 3'd0; wr_be = 4'h5;
        wr_req = 1'b1;
        @(negedge sys_clk); chk("t2_c1_idle", outs, IdleV);
        @(negedge sys_clk); chk("t2_c2_setup", outs, 8'b1_0_0_1111_1);
        wr_req = 1'b0;
        @(negedge sys_clk); chk("t2_c3_strobe", outs, 8'b1_1_1_1010_0);
        wait_idle();

        // T4: maximum counts
        start(3'd7, 3'd7, 3'd7, 4'b1010);
        n_strb = 0; n_ack = 0; n_busy = 0;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) @(negedge sys_clk);
            if (!n_r_wr) n_strb++;
            if (wr_ack) n_ack++;
            if (wr_busy) n_busy++;
        end
        chk("t4_strobe_len", 8'(n_strb), 8'd8);
        chk("t4_total_len", 8'(n_busy), 8'd22);
        chk("t4_ack_count", 8'(n_ack), 8'd1);
        wait_idle();

        // T5: asynchronous reset in the middle of STROBE
        start(3'd2, 3'd3, 3'd0, 4'hF);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("t5_in_strobe", outs, 8'b1_0_1_0000_0);
        #2 n_sys_reset = 1'b0;
        #1 chk("t5_async_reset", outs, IdleV);
        @(negedge sys_clk);
        @(negedge sys_clk);
        n_sys_reset = 1'b1;
        start(3'd0, 3'd1, 3'd1, 4'b0110);
        chk("t5_after_c0", outs, 8'b1_0_1_1001_0);
        wait_idle();

        // T6: no byte lanes enabled
        start(3'd0, 3'd1, 3'd0, 4'h0);
        chk("t6_c0", outs, 8'b1_0_1_1111_0);
        @(negedge sys_clk); chk("t6_c1_ack", outs, 8'b1_1_1_1111_0);
        @(negedge sys_clk); chk("t6_c2_idle", outs, IdleV);

        repeat (3) @(negedge sys_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
